// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding scoreboard: tracks in-flight destinations from EXE to WB,
// raises load-use/multicycle stalls and produces operand forward selects.
module pipe_hazard_unit #(
  parameter int DEPTH = 3,
  parameter int RN_W  = 5,
  parameter int RDY_W = 2,
  parameter int CNT_W = 16,
  localparam int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_flush,
  input  logic [RN_W-1:0]  id_rs,
  input  logic [RN_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_reg_write,
  input  logic [RN_W-1:0]  id_num_write,
  input  logic [RDY_W-1:0] id_ready_stage,
  input  logic             exe_busy,
  output logic             stall,
  output logic             id_fwd_rs,
  output logic             id_fwd_rt,
  output logic [SEL_W-1:0] ex_fwd_rs,
  output logic [SEL_W-1:0] ex_fwd_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [DEPTH:1]   v_r;
  logic [DEPTH:1]   wr_r;
  logic [RN_W-1:0]  num_r [1:DEPTH];
  logic [RDY_W-1:0] rdy_r [1:DEPTH];

  logic             live_s;
  logic             hz_s;
  logic [DEPTH:1]   rs_m_s, rt_m_s, late_s;
  logic [DEPTH:1]   rs_oh_s, rt_oh_s;
  logic [SEL_W-1:0] rs_nsel_s, rt_nsel_s;

  // Isolate the youngest (lowest-numbered) matching stage.
  function automatic logic [DEPTH:1] lowest(input logic [DEPTH:1] m);
    lowest = m & (~m + DEPTH'(1));
  endfunction

  function automatic logic [SEL_W-1:0] encode(input logic [DEPTH:1] oh);
    encode = {SEL_W{1'b0}};
    for (int k = 1; k <= DEPTH; k++) begin
      encode = encode | (oh[k] ? SEL_W'(k) : {SEL_W{1'b0}});
    end
  endfunction

  assign live_s = id_valid & ~id_flush;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    assign rs_m_s[k] = v_r[k] & wr_r[k] & (num_r[k] == id_rs) & id_use_rs &
                       (id_rs != {RN_W{1'b0}});
    assign rt_m_s[k] = v_r[k] & wr_r[k] & (num_r[k] == id_rt) & id_use_rt &
                       (id_rt != {RN_W{1'b0}});
    // Producer at stage k is late if its result only exists after stage k.
    assign late_s[k] = (32'(rdy_r[k]) > k);
  end

  assign rs_oh_s   = lowest(rs_m_s);
  assign rt_oh_s   = lowest(rt_m_s);
  assign hz_s      = live_s & ((|(rs_oh_s & late_s)) | (|(rt_oh_s & late_s)));
  assign stall     = exe_busy | hz_s;
  assign id_fwd_rs = live_s & rs_oh_s[DEPTH];
  assign id_fwd_rt = live_s & rt_oh_s[DEPTH];

  // Forward select the consumer will see in EXE: producer moves one stage on.
  always_comb begin
    rs_nsel_s = {SEL_W{1'b0}};
    rt_nsel_s = {SEL_W{1'b0}};
    if (live_s && (|rs_oh_s) && !rs_oh_s[DEPTH]) begin
      rs_nsel_s = encode(rs_oh_s) + SEL_W'(1);
    end else begin
      rs_nsel_s = {SEL_W{1'b0}};
    end
    if (live_s && (|rt_oh_s) && !rt_oh_s[DEPTH]) begin
      rt_nsel_s = encode(rt_oh_s) + SEL_W'(1);
    end else begin
      rt_nsel_s = {SEL_W{1'b0}};
    end
  end

  // Scoreboard shift, forward-select registers and saturating stall counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      v_r       <= {DEPTH{1'b0}};
      wr_r      <= {DEPTH{1'b0}};
      ex_fwd_rs <= {SEL_W{1'b0}};
      ex_fwd_rt <= {SEL_W{1'b0}};
      stall_cnt <= {CNT_W{1'b0}};
      for (int k = 1; k <= DEPTH; k++) begin
        num_r[k] <= {RN_W{1'b0}};
        rdy_r[k] <= {RDY_W{1'b0}};
      end
    end else begin
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (exe_busy) begin
        // Multicycle op stays in EXE; a bubble opens behind it.
        v_r[2] <= 1'b0;
        for (int k = 3; k <= DEPTH; k++) begin
          v_r[k]   <= v_r[k-1];
          wr_r[k]  <= wr_r[k-1];
          num_r[k] <= num_r[k-1];
          rdy_r[k] <= rdy_r[k-1];
        end
      end else begin
        for (int k = 2; k <= DEPTH; k++) begin
          v_r[k]   <= v_r[k-1];
          wr_r[k]  <= wr_r[k-1];
          num_r[k] <= num_r[k-1];
          rdy_r[k] <= rdy_r[k-1];
        end
        if (hz_s) begin
          v_r[1]    <= 1'b0;
          ex_fwd_rs <= {SEL_W{1'b0}};
          ex_fwd_rt <= {SEL_W{1'b0}};
        end else begin
          v_r[1]    <= live_s;
          wr_r[1]   <= id_reg_write;
          num_r[1]  <= id_num_write;
          rdy_r[1]  <= id_ready_stage;
          ex_fwd_rs <= rs_nsel_s;
          ex_fwd_rt <= rt_nsel_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed vector table, hand-written multicycle
// sequences, then random traffic against an instruction-list reference model.
module tb_pipe_hazard_unit;
  localparam int DEPTH = 3;
  localparam int RN_W  = 5;
  localparam int RDY_W = 2;
  localparam int CNT_W = 4;
  localparam int SEL_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset;
  logic             id_valid, id_flush;
  logic [RN_W-1:0]  id_rs, id_rt;
  logic             id_use_rs, id_use_rt, id_reg_write;
  logic [RN_W-1:0]  id_num_write;
  logic [RDY_W-1:0] id_ready_stage;
  logic             exe_busy;
  logic             stall, id_fwd_rs, id_fwd_rt;
  logic [SEL_W-1:0] ex_fwd_rs, ex_fwd_rt;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_hazard_unit #(.DEPTH(DEPTH), .RN_W(RN_W), .RDY_W(RDY_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_reg_write(id_reg_write), .id_num_write(id_num_write),
    .id_ready_stage(id_ready_stage), .exe_busy(exe_busy), .stall(stall),
    .id_fwd_rs(id_fwd_rs), .id_fwd_rt(id_fwd_rt), .ex_fwd_rs(ex_fwd_rs),
    .ex_fwd_rt(ex_fwd_rt), .stall_cnt(stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic rst, busy, valid, flush;
    int   rs, rt;
    logic urs, urt, rw;
    int   wn, rdy;
    logic est, efrs, efrt;
    int   exrs, exrt, cnt;
  } vec_t;

  function automatic vec_t mk(input logic rst, busy, valid, flush,
                              input int rs, rt, input logic urs, urt, rw,
                              input int wn, rdy, input logic est, efrs, efrt,
                              input int exrs, exrt, cnt);
    vec_t v;
    v.rst = rst; v.busy = busy; v.valid = valid; v.flush = flush;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.rw = rw;
    v.wn = wn; v.rdy = rdy; v.est = est; v.efrs = efrs; v.efrt = efrt;
    v.exrs = exrs; v.exrt = exrt; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, busy, valid, flush, input int rs, rt,
                       input logic urs, urt, rw, input int wn, rdy);
    reset = rst; exe_busy = busy; id_valid = valid; id_flush = flush;
    id_rs = RN_W'(rs); id_rt = RN_W'(rt); id_use_rs = urs; id_use_rt = urt;
    id_reg_write = rw; id_num_write = RN_W'(wn); id_ready_stage = RDY_W'(rdy);
  endtask

  // Called at posedge+1: drive, check combinational outputs, clock, check registers.
  task automatic run_vec(input vec_t v, input string tag);
    drive(v.rst, v.busy, v.valid, v.flush, v.rs, v.rt, v.urs, v.urt, v.rw, v.wn, v.rdy);
    #3;
    check({tag, ".stall"}, int'(stall), int'(v.est));
    check({tag, ".id_fwd_rs"}, int'(id_fwd_rs), int'(v.efrs));
    check({tag, ".id_fwd_rt"}, int'(id_fwd_rt), int'(v.efrt));
    @(posedge clock);
    #1;
    check({tag, ".ex_fwd_rs"}, int'(ex_fwd_rs), v.exrs);
    check({tag, ".ex_fwd_rt"}, int'(ex_fwd_rt), v.exrt);
    check({tag, ".stall_cnt"}, int'(stall_cnt), v.cnt);
  endtask

  // Reference model: list of in-flight register writers with their current stage.
  typedef struct { int num; int rdy; int stage; } ent_t;
  ent_t q[$];

  function automatic void producer(input int r, input logic use_r, output int st, output int rd);
    st = 0;
    rd = 0;
    if (use_r && r != 0) begin
      foreach (q[i]) begin
        if (q[i].num == r && (st == 0 || q[i].stage < st)) begin
          st = q[i].stage;
          rd = q[i].rdy;
        end
      end
    end
  endfunction

  function automatic void advance(input int from);
    foreach (q[i]) if (q[i].stage >= from) q[i].stage++;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].stage > DEPTH) q.delete(i);
  endfunction

  vec_t tbl[16];

  initial begin
    int m_exrs, m_exrt, m_cnt, ps, pr, ts, tr;
    logic live, hz, est;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    @(posedge clock);
    #1;

    //             rst busy v  fl  rs rt urs urt rw wn rdy st  frs frt exrs exrt cnt
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 1, 2, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0, 3, 0, 1, 0, 1, 8, 1, 0, 0, 0, 2, 0, 0);
    tbl[3]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 5, 2, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 1, 0, 3, 5, 1, 1, 1, 9, 1, 1, 1, 0, 0, 0, 1);
    tbl[5]  = mk(0, 0, 1, 0, 3, 5, 1, 1, 1, 9, 1, 0, 0, 0, 0, 3, 1);
    tbl[6]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 7, 3, 0, 0, 0, 0, 0, 1);
    tbl[7]  = mk(0, 0, 1, 0, 7, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2);
    tbl[8]  = mk(0, 0, 1, 0, 7, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3);
    tbl[9]  = mk(0, 0, 1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3);
    tbl[10] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 3);
    tbl[11] = mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    tbl[12] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 4, 2, 0, 0, 0, 0, 0, 3);
    tbl[13] = mk(0, 0, 1, 1, 4, 0, 1, 0, 1, 4, 3, 0, 0, 0, 0, 0, 3);
    tbl[14] = mk(0, 0, 1, 0, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 3);
    tbl[15] = mk(0, 0, 1, 0, 4, 4, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 3);
    for (int i = 0; i < 16; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Multicycle EXE occupancy, then reset in the middle of a busy run.
    run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "busy.rst");
    run_vec(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0, 0, 0), "busy.w6");
    run_vec(mk(0, 0, 1, 0, 6, 0, 1, 0, 1, 2, 1, 0, 0, 0, 2, 0, 0), "busy.w2");
    for (int i = 1; i <= 4; i++)
      run_vec(mk(0, 1, 1, 0, 0, 2, 0, 1, 1, 2, 3, 1, 0, 0, 2, 0, i), $sformatf("busy.c%0d", i));
    run_vec(mk(0, 0, 1, 0, 0, 2, 0, 1, 1, 2, 3, 0, 0, 0, 0, 2, 4), "busy.held");
    run_vec(mk(0, 1, 1, 0, 0, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0, 2, 5), "busy.f1");
    run_vec(mk(0, 1, 1, 0, 0, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0, 2, 6), "busy.f2");
    run_vec(mk(1, 1, 1, 0, 0, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0), "busy.f3rst");
    run_vec(mk(0, 0, 1, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "busy.clean");
    for (int i = 1; i <= 18; i++)
      run_vec(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, (i < CMAX) ? i : CMAX),
              $sformatf("sat%0d", i));
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CMAX), "sat.hold");
    run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rnd.rst");

    // Random traffic against the reference model.
    q.delete();
    m_exrs = 0; m_exrt = 0; m_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)));
      live = id_valid && !id_flush;
      producer(int'(id_rs), id_use_rs, ps, pr);
      producer(int'(id_rt), id_use_rt, ts, tr);
      hz  = live && ((ps != 0 && ps < pr) || (ts != 0 && ts < tr));
      est = exe_busy || hz;
      #3;
      check($sformatf("rnd%0d.stall", c), int'(stall), int'(est));
      check($sformatf("rnd%0d.id_fwd_rs", c), int'(id_fwd_rs), int'(live && ps == DEPTH));
      check($sformatf("rnd%0d.id_fwd_rt", c), int'(id_fwd_rt), int'(live && ts == DEPTH));
      if (reset) begin
        q.delete();
        m_exrs = 0; m_exrt = 0; m_cnt = 0;
      end else begin
        if (est && m_cnt < CMAX) m_cnt++;
        if (exe_busy) begin
          advance(2);
        end else begin
          advance(1);
          if (hz) begin
            m_exrs = 0; m_exrt = 0;
          end else begin
            if (live && id_reg_write) q.push_back('{int'(id_num_write), int'(id_ready_stage), 1});
            m_exrs = (live && ps != 0 && ps < DEPTH) ? ps + 1 : 0;
            m_exrt = (live && ts != 0 && ts < DEPTH) ? ts + 1 : 0;
          end
        end
      end
      @(posedge clock);
      #1;
      check($sformatf("rnd%0d.ex_fwd_rs", c), int'(ex_fwd_rs), m_exrs);
      check($sformatf("rnd%0d.ex_fwd_rt", c), int'(ex_fwd_rt), m_exrt);
      check($sformatf("rnd%0d.stall_cnt", c), int'(stall_cnt), m_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
